// File: rtl/case_mux_pkg.sv
// Shared definitions for the case_mux_scan block: mode encoding and the select range rule.
package case_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // A select code addresses a real channel only when it is below the channel count.
  function automatic logic in_range(input int unsigned sel, input int unsigned n);
    return sel < n;
  endfunction

endpackage

// File: rtl/case_mux_scan_if.sv
// Host-side bundle of the case_mux_scan block; sel_err exists only with CASE_MUX_SCAN_ERR_EN.
interface case_mux_scan_if #(
  parameter int N_IN = 3,
  parameter int DW   = 1,
  parameter int SELW = 2
);

  logic                 mode;
  logic                 sel_wr;
  logic [SELW-1:0]      sel_in;
  logic [N_IN*DW-1:0]   din;
  logic [DW-1:0]        x;
  logic [DW-1:0]        y;
  logic [SELW-1:0]      sel_q;
  logic                 out_valid;
`ifdef CASE_MUX_SCAN_ERR_EN
  logic                 sel_err;

  modport master (output mode, sel_wr, sel_in, din,
                  input  x, y, sel_q, out_valid, sel_err);
  modport slave  (input  mode, sel_wr, sel_in, din,
                  output x, y, sel_q, out_valid, sel_err);
`else
  modport master (output mode, sel_wr, sel_in, din,
                  input  x, y, sel_q, out_valid);
  modport slave  (input  mode, sel_wr, sel_in, din,
                  output x, y, sel_q, out_valid);
`endif

endinterface

// File: rtl/case_mux_scan_ctr.sv
// Select source: host-loaded register in manual mode, divided wrapping counter in scan mode.
module case_mux_scan_ctr
  import case_mux_pkg::*;
#(
  parameter int SELW     = 2,
  parameter int SCAN_DIV = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            mode,
  input  logic            sel_wr,
  input  logic [SELW-1:0] sel_in,
  output logic [SELW-1:0] sel_q,
  output logic            upd
);

  localparam int              DIVW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SCAN_DIV - 1);

  logic [DIVW-1:0] div_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      sel_q <= '0;
      upd   <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignment so every flop samples pre-edge values;
      // the default below is overridden later in the same block by any load or step.
      upd <= 1'b0;
      if (mode == MODE_MANUAL) begin
        div_q <= '0;
        if (sel_wr) begin
          sel_q <= sel_in;
          upd   <= 1'b1;
        end
      end else if (div_q == DIV_LAST) begin
        div_q <= '0;
        sel_q <= sel_q + 1'b1;  // wraps modulo 2**SELW, visiting unused codes too
        upd   <= 1'b1;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/case_mux_scan.sv
// Registered N-input case-mux with full-case (x) and hold (y) outputs.
// Optional sticky out-of-range flag sel_err under CASE_MUX_SCAN_ERR_EN.
module case_mux_scan
  import case_mux_pkg::*;
#(
  parameter int             N_IN      = 3,
  parameter int             DW        = 1,
  parameter int             SELW      = 2,
  parameter int             SCAN_DIV  = 4,
  parameter logic [DW-1:0]  X_DEFAULT = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  case_mux_scan_if.slave   bus
);

  logic [SELW-1:0] sel_q;
  logic            upd;
  logic            sel_ok;
  logic [DW-1:0]   sel_data;

  case_mux_scan_ctr #(
    .SELW     (SELW),
    .SCAN_DIV (SCAN_DIV)
  ) u_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .mode    (bus.mode),
    .sel_wr  (bus.sel_wr),
    .sel_in  (bus.sel_in),
    .sel_q   (sel_q),
    .upd     (upd)
  );

  assign bus.sel_q = sel_q;
  assign sel_ok    = in_range(32'(sel_q), 32'(N_IN));

  always_comb begin
    // NOTE: the default assignment makes the decode full-case, so no latch is inferred.
    sel_data = X_DEFAULT;
    for (int k = 0; k < N_IN; k++) begin
      if (sel_q == SELW'(k)) sel_data = bus.din[k*DW +: DW];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.x         <= '0;
      bus.y         <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.x         <= sel_data;
      bus.out_valid <= upd;
      if (sel_ok) bus.y <= sel_data;  // explicit hold flop instead of a partial case
    end
  end

`ifdef CASE_MUX_SCAN_ERR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.sel_err <= 1'b0;
    end else if (bus.mode == MODE_MANUAL && bus.sel_wr &&
                 in_range(32'(bus.sel_in), 32'(N_IN))) begin
      bus.sel_err <= 1'b0;
    end else if (!sel_ok) begin
      bus.sel_err <= 1'b1;
    end
  end
`endif

endmodule
